// File: rtl/alu_dispatch.sv
// Command FIFO and single-outstanding issue sequencer in front of the multi-cycle ALU.
// Optional completed-operation counter enabled by defining ALU_DISPATCH_STATS_EN.
module alu_dispatch #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [4:0]   cmd_opcode,
    input  logic [N-1:0] cmd_A,
    input  logic [N-1:0] cmd_B,
    output logic         alu_start,
    input  logic         alu_finished,
    output logic [4:0]   alu_opcode,
    output logic [N-1:0] alu_A,
    output logic [N-1:0] alu_B,
    input  logic [N-1:0] alu_Y,
    input  logic [N-1:0] alu_X,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [4:0]   res_opcode,
    output logic [N-1:0] res_Y,
    output logic [N-1:0] res_X,
    output logic [15:0]  ops_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef struct packed {
        logic [4:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [4:0]    r_alu_op;
    logic [N-1:0]  r_alu_a;
    logic [N-1:0]  r_alu_b;
    logic          r_res_valid;
    logic [4:0]    r_res_op;
    logic [N-1:0]  r_res_y;
    logic [N-1:0]  r_res_x;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    cmd_t w_head;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    // Gated by reset so the port reads 0 while held in reset even though the FIFO is empty.
    assign cmd_ready = reset && !w_full;
    assign w_push  = cmd_valid && cmd_ready;
    assign w_pop   = !w_empty &&
                     ((r_state == ST_IDLE) || (r_state == ST_HOLD && res_ready));
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= '{op: cmd_opcode, a: cmd_A, b: cmd_B};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_op    <= '0;
            r_res_y     <= '0;
            r_res_x     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_alu_op <= w_head.op;
                        r_alu_a  <= w_head.a;
                        r_alu_b  <= w_head.b;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (alu_finished) begin
                        r_res_y     <= alu_Y;
                        r_res_x     <= alu_X;
                        r_res_op    <= r_alu_op;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Popping on the handshake cycle skips IDLE for back-to-back issue.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_op <= w_head.op;
                            r_alu_a  <= w_head.a;
                            r_alu_b  <= w_head.b;
                            r_state  <= ST_ISSUE;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_start  = (r_state == ST_ISSUE);
    assign alu_opcode = r_alu_op;
    assign alu_A      = r_alu_a;
    assign alu_B      = r_alu_b;
    assign res_valid  = r_res_valid;
    assign res_opcode = r_res_op;
    assign res_Y      = r_res_y;
    assign res_X      = r_res_x;

`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] r_ops_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_ops_done <= '0;
        else if (r_res_valid && res_ready)
            r_ops_done <= r_ops_done + 16'd1;
    end

    assign ops_done = r_ops_done;
`else
    assign ops_done = '0;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch with a behavioural multi-cycle ALU model.
module tb_alu_dispatch;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [4:0]   cmd_opcode = '0;
    logic [N-1:0] cmd_A = '0;
    logic [N-1:0] cmd_B = '0;
    logic         alu_start;
    logic         alu_finished;
    logic [4:0]   alu_opcode;
    logic [N-1:0] alu_A, alu_B, alu_Y, alu_X;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [4:0]   res_opcode;
    logic [N-1:0] res_Y, res_X;
    logic [15:0]  ops_done;

    always #5 clock = ~clock;

    alu_dispatch #(.N(N), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_A(cmd_A), .cmd_B(cmd_B),
        .alu_start(alu_start), .alu_finished(alu_finished), .alu_opcode(alu_opcode),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Y(alu_Y), .alu_X(alu_X),
        .res_valid(res_valid), .res_ready(res_ready), .res_opcode(res_opcode),
        .res_Y(res_Y), .res_X(res_X), .ops_done(ops_done)
    );

    typedef struct packed {
        logic [4:0]   op;
        logic [N-1:0] y;
        logic [N-1:0] x;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    int   lat = 3;
    logic spur_fin = 1'b0;
    int   n_acc = 0, n_start = 0, n_hs = 0, n_vcyc = 0;
    logic [15:0] exp_ops = '0;

    // ALU reference: Y = A+B (truncated), X = carry out
    function automatic res_t exp_of(input logic [4:0] op, input logic [N-1:0] a,
                                    input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        return '{op: op, y: s[N-1:0], x: {{(N-1){1'b0}}, s[N]}};
    endfunction

    logic [7:0]   m_cnt;
    logic         m_fin;
    logic [N-1:0] m_y, m_x;
    res_t         m_r;
    assign m_r = exp_of(alu_opcode, alu_A, alu_B);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt <= '0; m_fin <= 1'b0; m_y <= '0; m_x <= '0;
        end else begin
            m_fin <= 1'b0;
            if (alu_start) begin
                m_cnt <= 8'(lat);
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 8'd1;
                if (m_cnt == 8'd1) begin
                    m_fin <= 1'b1; m_y <= m_r.y; m_x <= m_r.x;
                end
            end
        end
    end
    assign alu_finished = m_fin | spur_fin;
    assign alu_Y = m_y;
    assign alu_X = m_x;

    // Scoreboard: push on accepted command, pop/compare on result handshake
    always @(negedge clock) begin
        if (!reset) begin
            exp_ops = '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(exp_of(cmd_opcode, cmd_A, cmd_B));
                n_acc++;
            end
            if (alu_start) begin
                n_start++;
                checks++;
                if (m_cnt != 0) begin
                    errors++;
                    $display("FAIL one_outstanding: start while ALU busy cnt=%0d", m_cnt);
                end
            end
            checks++;
            if (ops_done !== exp_ops) begin
                errors++;
                $display("FAIL ops_done: got %h want %h", ops_done, exp_ops);
            end
            if (res_valid) n_vcyc++;
            if (res_valid && res_ready) begin
                n_hs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_extra: op=%0d Y=%h X=%h with nothing expected",
                             res_opcode, res_Y, res_X);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    if ({res_opcode, res_Y, res_X} !== e) begin
                        errors++;
                        $display("FAIL result: got op=%0d Y=%h X=%h want op=%0d Y=%h X=%h",
                                 res_opcode, res_Y, res_X, e.op, e.y, e.x);
                    end
                end
`ifdef ALU_DISPATCH_STATS_EN
                exp_ops = exp_ops + 16'd1;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic push_cmd(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int t;
        t = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_A = a; cmd_B = b;
        @(negedge clock);
        while (!cmd_ready && t < 200) begin @(negedge clock); t++; end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL push_timeout: cmd_ready=%b want 1", cmd_ready);
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || res_valid) && t < 400) begin tick(); t++; end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, want 0", nm, exp_q.size());
        end
        tick();
    endtask

    task automatic wait_res_valid(input string nm);
        int t;
        t = 0;
        while (!res_valid && t < 100) begin tick(); t++; end
        checks++;
        if (!res_valid) begin
            errors++;
            $display("FAIL %s_res_valid_timeout: res_valid=%b want 1", nm, res_valid);
        end
    endtask

    task automatic check_all_zero(input string nm);
        logic [3+5+3*N+1+5+2*N+16-1:0] obs;
        obs = {cmd_ready, alu_start, res_valid, alu_opcode, alu_A, alu_B,
               res_opcode, res_Y, res_X, ops_done};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h want 0", nm, obs);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1 check_all_zero("reset_por");
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b res_valid=%b want 1/0", cmd_ready, res_valid);
        end
        tick();
    endtask

    task automatic test_single();
        int s0, h0, v0;
        lat = 3; res_ready = 1'b1;
        s0 = n_start; h0 = n_hs; v0 = n_vcyc;
        push_cmd(5'd3, 4'd5, 4'd9);
        @(negedge clock);
        checks++;
        if (alu_start !== 1'b0) begin
            errors++; $display("FAIL single_start_early: alu_start=%b want 0", alu_start);
        end
        @(negedge clock);
        checks++;
        if ({alu_start, alu_opcode, alu_A, alu_B} !== {1'b1, 5'd3, 4'd5, 4'd9}) begin
            errors++;
            $display("FAIL single_issue: start=%b op=%0d A=%h B=%h want 1 3 5 9",
                     alu_start, alu_opcode, alu_A, alu_B);
        end
        drain("single");
        checks++;
        if (n_start - s0 != 1 || n_hs - h0 != 1 || n_vcyc - v0 != 1) begin
            errors++;
            $display("FAIL single_counts: starts=%0d hs=%0d valid_cycles=%0d want 1 1 1",
                     n_start - s0, n_hs - h0, n_vcyc - v0);
        end
    endtask

    task automatic test_full();
        int k, acc0, h0;
        lat = 2; res_ready = 1'b0;
        k = 0; acc0 = n_acc; h0 = n_hs;
        cmd_valid = 1'b1;
        cmd_opcode = 5'(k + 1); cmd_A = N'(k * 3); cmd_B = N'(k + 7);
        repeat (10) begin
            @(negedge clock);
            if (cmd_ready) k++;
            @(posedge clock); #1;
            cmd_opcode = 5'(k + 1); cmd_A = N'(k * 3); cmd_B = N'(k + 7);
        end
        #1;
        checks++;
        if (n_acc - acc0 != 5 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_accept: accepted=%0d cmd_ready=%b want 5 0", n_acc - acc0, cmd_ready);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain("full");
        checks++;
        if (n_hs - h0 != 5) begin
            errors++; $display("FAIL full_results: got %0d want 5", n_hs - h0);
        end
    endtask

    task automatic test_hold();
        logic [5+2*N-1:0] snap;
        int s0;
        lat = 4; res_ready = 1'b0;
        push_cmd(5'd7, 4'hA, 4'h9);
        wait_res_valid("hold");
        snap = {res_opcode, res_Y, res_X};
        s0 = n_start;
        push_cmd(5'd8, 4'h1, 4'h2);
        for (int i = 0; i < 10; i++) begin
            spur_fin = (i == 3);
            @(negedge clock);
            checks++;
            if (res_valid !== 1'b1 || {res_opcode, res_Y, res_X} !== snap) begin
                errors++;
                $display("FAIL hold_stable: valid=%b res=%h want 1 %h", res_valid,
                         {res_opcode, res_Y, res_X}, snap);
            end
            @(posedge clock); #1;
        end
        spur_fin = 1'b0;
        checks++;
        if (n_start != s0) begin
            errors++; $display("FAIL hold_no_start: starts=%0d want 0", n_start - s0);
        end
        res_ready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        res_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (alu_start !== 1'b1) begin
            errors++; $display("FAIL hold_b2b_start: alu_start=%b want 1", alu_start);
        end
        res_ready = 1'b1;
        drain("hold");
    endtask

    task automatic test_same_cycle();
        lat = 2; res_ready = 1'b0;
        push_cmd(5'd10, 4'h2, 4'h3);
        push_cmd(5'd11, 4'h4, 4'h5);
        push_cmd(5'd12, 4'h6, 4'h7);
        wait_res_valid("same");
        checks++;
        if (dut.r_count !== 3'd2) begin
            errors++; $display("FAIL same_pre_count: got %0d want 2", dut.r_count);
        end
        cmd_valid = 1'b1; cmd_opcode = 5'd13; cmd_A = 4'hF; cmd_B = 4'h1;
        res_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL same_precond: cmd_ready=%b res_valid=%b want 1 1", cmd_ready, res_valid);
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0; res_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (dut.r_count !== 3'd2) begin
            errors++; $display("FAIL same_count: got %0d want 2", dut.r_count);
        end
        res_ready = 1'b1;
        drain("same");
    endtask

    task automatic test_wrap();
        int h0;
        h0 = n_hs; res_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            lat = $urandom_range(1, 5);
            push_cmd(5'(16 + i), N'($urandom), N'($urandom));
        end
        drain("wrap");
        checks++;
        if (n_hs - h0 != 9) begin
            errors++; $display("FAIL wrap_results: got %0d want 9", n_hs - h0);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        lat = 10; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(5'(i + 1), N'(i), N'(i + 2));
        tick(); tick();
        #2 reset = 1'b0;
        #1 check_all_zero("reset_mid");
        exp_q.delete();
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: cmd_ready=%b res_valid=%b want 1 0", cmd_ready, res_valid);
        end
        s0 = n_start;
        repeat (20) tick();
        checks++;
        if (n_start != s0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: starts=%0d res_valid=%b want 0 0", n_start - s0, res_valid);
        end
    endtask

    task automatic test_stats();
        lat = 2; res_ready = 1'b1;
        tick();
        #2 reset = 1'b0;
        tick();
        #2 reset = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push_cmd(5'(i + 20), N'(i), N'(3 * i));
        drain("stats");
        checks++;
`ifdef ALU_DISPATCH_STATS_EN
        if (ops_done !== 16'd5) begin
            errors++; $display("FAIL stats_count: got %0d want 5", ops_done);
        end
        force dut.r_ops_done = 16'hFFFD;
        exp_ops = 16'hFFFD;
        #1 release dut.r_ops_done;
        for (int i = 0; i < 5; i++) push_cmd(5'(i + 25), N'(i + 1), N'(i));
        drain("stats_wrap");
        checks++;
        if (ops_done !== 16'd2) begin
            errors++; $display("FAIL stats_wrap: got %h want 0002", ops_done);
        end
`else
        if (ops_done !== 16'd0) begin
            errors++; $display("FAIL stats_disabled: got %0d want 0", ops_done);
        end
`endif
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_full();
        test_hold();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Upstream operation queue and issue sequencer for the multi-cycle `ALU`. Buffers up to `DEPTH` operations (opcode plus operands) from a valid/ready command port, issues them one at a time over the ALU's `start`/`finished` handshake, and presents each captured `Y`/`X` pair on a valid/ready result port. It sits directly in front of `ALU` and drives its `opcode`, `A`, `B` and `start` pins.

## Interface
- `N`, 4: operand/result width; must match the `ALU` instance.
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 resets all state immediately.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command; equals `!full`.
- `cmd_opcode` in 5: ALU opcode.
- `cmd_A`, `cmd_B` in N: operands.
- `alu_start` out 1: one-cycle start pulse to the ALU.
- `alu_finished` in 1: ALU completion.
- `alu_opcode` out 5, `alu_A` out N, `alu_B` out N: registered operands, held stable from issue until completion.
- `alu_Y`, `alu_X` in N: ALU results.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer accepts the result.
- `res_opcode` out 5, `res_Y` out N, `res_X` out N: captured result and the opcode that produced it.
- `ops_done` out 16: completed-operation count (see Configuration).

## Operation
- **FIFO**
  - A push occurs when `cmd_valid && cmd_ready`.
  - A pop is performed only by the FSM and only when the FIFO is not empty.
  - Pointers are `log2(DEPTH)` bits wide and wrap naturally.
  - The count is `log2(DEPTH)+1` bits wide.
  - Push and pop in the same cycle is legal when not full: the count is unchanged.
  - When full, `cmd_ready` is 0 even if a pop happens in that cycle. There is no bypass.
- **FSM states**
  - IDLE: if the FIFO is not empty, pop the head into `alu_opcode`/`alu_A`/`alu_B` and go to ISSUE.
  - ISSUE: `alu_start`=1 for this cycle only; go to WAIT.
  - WAIT: hold the operands. On the first cycle `alu_finished`=1, register `alu_Y`, `alu_X` and `alu_opcode` into `res_*`, set `res_valid`=1, and go to HOLD. `alu_finished` in any other state is ignored.
  - HOLD: `res_*` are stable while `res_valid`=1. When `res_ready`=1:
    - `res_valid` clears on the next edge.
    - If the FIFO is not empty in that same cycle, pop and go directly to ISSUE.
    - Otherwise go to IDLE.
- **Result rules**
  - `res_valid` never drops without `res_ready`.
  - Only one operation is ever outstanding at the ALU.
- **Reset values:** all of the following are 0, and the FSM is in IDLE:
  - `cmd_ready` (FIFO empty gives 1 only after reset deasserts; it reads 0 during reset)
  - `alu_start`, `alu_opcode`, `alu_A`, `alu_B`
  - `res_valid`, `res_opcode`, `res_Y`, `res_X`
  - `ops_done`
  - FIFO pointers and count
- **Reset mid-operation:** queued and in-flight operations are discarded and no result is produced. The ALU shares `reset`.

## Timing
- Command accepted at edge t: pop at edge t+1, `alu_start` high during cycle t+1..t+2 (one cycle).
- ALU completes with `alu_finished` sampled high at edge s: `res_valid` high from edge s onward.
- End-to-end latency on an empty pipe is 2 cycles plus ALU latency plus 1 registered capture.
- Back-to-back issue: when `res_ready` is already high at HOLD entry and the FIFO is not empty, the next `alu_start` fires 1 cycle after the result handshake.
- `cmd_ready` is combinational from the count only; it has no path from `res_ready` or `cmd_valid`.

## Configuration
- `ALU_DISPATCH_STATS_EN`
  - Defined: `ops_done` increments by 1 on each result handshake (`res_valid && res_ready`) and wraps from 0xFFFF to 0.
  - Undefined: the counter logic is not compiled and `ops_done` is tied to 0.

## Test plan
- Reset with `reset`=0 mid-WAIT, FIFO holding 3 ops -> all outputs 0 immediately. After release: `cmd_ready`=1, no `res_valid`, and `alu_start` stays 0 with no new commands.
- N=4, push opcode 3, A=5, B=9, with the ALU model returning Y=0xE, X=0 after 3 cycles and `res_ready`=1 -> exactly one `alu_start` pulse; `res_Y`=0xE, `res_X`=0, `res_opcode`=3; `res_valid` for 1 cycle.
- DEPTH=4, `res_ready`=0, push 6 commands back-to-back -> 5 accepted (1 in flight, 4 queued) and `cmd_ready`=0 at count 4. Releasing `res_ready` returns results in push order with no loss or duplication.
- Hold `res_ready`=0 for 10 cycles after `res_valid` -> `res_*` unchanged and no new `alu_start`. Raising `res_ready` -> next `alu_start` 1 cycle later.
- Push and pop in the same cycle with count 2 -> count stays 2. Run 9 ops through DEPTH=4 -> pointers wrap with correct ordering.
- With `ALU_DISPATCH_STATS_EN`: 5 completed ops give `ops_done`=5; preload near the limit gives wrap 0xFFFF->0. Without the macro, `ops_done`=0 throughout.
